// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word layout, ALU op encodings and the ID/EX update modes.
package pipeline_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_A_W = 5;
    localparam int CTRL_W  = 9;

    localparam int CTRL_REG_WRITE = 8;
    localparam int CTRL_MEM_READ  = 7;
    localparam int CTRL_MEM_WRITE = 6;
    localparam int CTRL_MEM_2_REG = 5;
    localparam int CTRL_ALU_SRC   = 4;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_JUMP      = 2;
    localparam int CTRL_ALU_OP    = 0;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_BR    = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    typedef enum logic [1:0] {
        UPD_FLUSH   = 2'd0,
        UPD_HOLD    = 2'd1,
        UPD_BUBBLE  = 2'd2,
        UPD_CAPTURE = 2'd3
    } upd_mode_e;

    function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async active-low reset, synchronous clear, load, otherwise hold.
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Field storage: clear beats load, otherwise hold
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_r <= {W{1'b0}};
        end else if (clear) begin
            q_r <= {W{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/id_exe_pipeline_reg.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Optional saturating bubble/flush statistics counters are built when ID_EXE_STATS_EN is defined.
module id_exe_pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = pipeline_pkg::DATA_W,
    parameter int REG_A_W = pipeline_pkg::REG_A_W
`ifdef ID_EXE_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               enable,
    input  logic               stall_control,
    input  logic               flush,
    input  logic               valid_IF_ID,
    input  logic [CTRL_W-1:0]  ctrl_IF_ID,
    input  logic [DATA_W-1:0]  pc_IF_ID,
    input  logic [DATA_W-1:0]  rs1_data_IF_ID,
    input  logic [DATA_W-1:0]  rs2_data_IF_ID,
    input  logic [DATA_W-1:0]  imm_IF_ID,
    input  logic [REG_A_W-1:0] rs1_IF_ID,
    input  logic [REG_A_W-1:0] rs2_IF_ID,
    input  logic [REG_A_W-1:0] rd_IF_ID,
    input  logic [3:0]         func_IF_ID,
    output logic               valid_ID_EXE,
    output logic [CTRL_W-1:0]  ctrl_ID_EXE,
    output logic [DATA_W-1:0]  pc_ID_EXE,
    output logic [DATA_W-1:0]  rs1_data_ID_EXE,
    output logic [DATA_W-1:0]  rs2_data_ID_EXE,
    output logic [DATA_W-1:0]  imm_ID_EXE,
    output logic [REG_A_W-1:0] rs1_ID_EXE,
    output logic [REG_A_W-1:0] rs2_ID_EXE,
    output logic [REG_A_W-1:0] rd_ID_EXE,
    output logic [3:0]         func_ID_EXE,
    output logic               mem_read_ID_EXE
`ifdef ID_EXE_STATS_EN
    , output logic [CNT_W-1:0] bubble_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int CTRL_GRP_W = 1 + CTRL_W + REG_A_W;
    localparam int DATA_GRP_W = 4 * DATA_W + 4;
    localparam int ADDR_GRP_W = 2 * REG_A_W;

    upd_mode_e mode_s;
    logic ctrl_load_s, ctrl_clear_s, data_load_s, addr_load_s, addr_clear_s;
    logic [CTRL_GRP_W-1:0] ctrl_d_s, ctrl_q_s;
    logic [DATA_GRP_W-1:0] data_d_s, data_q_s;
    logic [ADDR_GRP_W-1:0] addr_d_s, addr_q_s;

    // Update priority: flush overrides a global hold, which overrides a bubble
    always_comb begin
        mode_s = UPD_CAPTURE;
        if (flush) begin
            mode_s = UPD_FLUSH;
        end else if (!enable) begin
            mode_s = UPD_HOLD;
        end else if (!stall_control) begin
            mode_s = UPD_BUBBLE;
        end else begin
            mode_s = UPD_CAPTURE;
        end
    end

    // Per-group load/clear strobes for the selected update mode
    always_comb begin
        ctrl_load_s  = 1'b0;
        ctrl_clear_s = 1'b0;
        data_load_s  = 1'b0;
        addr_load_s  = 1'b0;
        addr_clear_s = 1'b0;
        case (mode_s)
            UPD_FLUSH:   ctrl_clear_s = 1'b1;
            UPD_HOLD:    ctrl_clear_s = 1'b0;
            UPD_BUBBLE: begin
                ctrl_clear_s = 1'b1;
                addr_clear_s = 1'b1;
            end
            UPD_CAPTURE: begin
                ctrl_load_s = 1'b1;
                data_load_s = 1'b1;
                addr_load_s = 1'b1;
            end
            default: ctrl_clear_s = 1'b1;
        endcase
    end

    // An invalid slot enters EXE with no control and no destination
    always_comb begin
        if (valid_IF_ID) begin
            ctrl_d_s = {1'b1, ctrl_IF_ID, rd_IF_ID};
        end else begin
            ctrl_d_s = {CTRL_GRP_W{1'b0}};
        end
    end

    assign data_d_s = {pc_IF_ID, rs1_data_IF_ID, rs2_data_IF_ID, imm_IF_ID, func_IF_ID};
    assign addr_d_s = {rs1_IF_ID, rs2_IF_ID};

    pipe_field_reg #(.W(CTRL_GRP_W)) u_ctrl_reg (
        .clk(clk), .arst_n(arst_n), .load(ctrl_load_s), .clear(ctrl_clear_s),
        .d(ctrl_d_s), .q(ctrl_q_s)
    );

    pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
        .clk(clk), .arst_n(arst_n), .load(data_load_s), .clear(1'b0),
        .d(data_d_s), .q(data_q_s)
    );

    pipe_field_reg #(.W(ADDR_GRP_W)) u_addr_reg (
        .clk(clk), .arst_n(arst_n), .load(addr_load_s), .clear(addr_clear_s),
        .d(addr_d_s), .q(addr_q_s)
    );

    assign {valid_ID_EXE, ctrl_ID_EXE, rd_ID_EXE} = ctrl_q_s;
    assign {pc_ID_EXE, rs1_data_ID_EXE, rs2_data_ID_EXE, imm_ID_EXE, func_ID_EXE} = data_q_s;
    assign {rs1_ID_EXE, rs2_ID_EXE} = addr_q_s;
    assign mem_read_ID_EXE = ctrl_mem_read(ctrl_ID_EXE);

`ifdef ID_EXE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] bubble_cnt_r, flush_cnt_r;

    // Saturating event counters; a flush only counts if it kills a real instruction
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (mode_s == UPD_BUBBLE && bubble_cnt_r != CNT_MAX) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (mode_s == UPD_FLUSH && valid_ID_EXE && flush_cnt_r != CNT_MAX) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_exe_pipeline_reg.sv
// Scoreboard bench for id_exe_pipeline_reg: directed scenarios plus randomized traffic against a
// behavioural model of the ID/EX slot. Counter checks are active when ID_EXE_STATS_EN is defined.
module tb_id_exe_pipeline_reg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          enable = 1'b0, stall_control = 1'b1, flush = 1'b0, valid_IF_ID = 1'b0;
    logic [8:0]    ctrl_IF_ID = 9'd0;
    logic [DW-1:0] pc_IF_ID = 32'd0, rs1_data_IF_ID = 32'd0, rs2_data_IF_ID = 32'd0, imm_IF_ID = 32'd0;
    logic [AW-1:0] rs1_IF_ID = 5'd0, rs2_IF_ID = 5'd0, rd_IF_ID = 5'd0;
    logic [3:0]    func_IF_ID = 4'd0;

    logic          valid_ID_EXE, mem_read_ID_EXE;
    logic [8:0]    ctrl_ID_EXE;
    logic [DW-1:0] pc_ID_EXE, rs1_data_ID_EXE, rs2_data_ID_EXE, imm_ID_EXE;
    logic [AW-1:0] rs1_ID_EXE, rs2_ID_EXE, rd_ID_EXE;
    logic [3:0]    func_ID_EXE;
`ifdef ID_EXE_STATS_EN
    logic [CW-1:0] bubble_cnt, flush_cnt;
`endif

    id_exe_pipeline_reg #(
        .DATA_W(DW), .REG_A_W(AW)
`ifdef ID_EXE_STATS_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .stall_control(stall_control), .flush(flush),
        .valid_IF_ID(valid_IF_ID), .ctrl_IF_ID(ctrl_IF_ID), .pc_IF_ID(pc_IF_ID),
        .rs1_data_IF_ID(rs1_data_IF_ID), .rs2_data_IF_ID(rs2_data_IF_ID), .imm_IF_ID(imm_IF_ID),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID), .rd_IF_ID(rd_IF_ID), .func_IF_ID(func_IF_ID),
        .valid_ID_EXE(valid_ID_EXE), .ctrl_ID_EXE(ctrl_ID_EXE), .pc_ID_EXE(pc_ID_EXE),
        .rs1_data_ID_EXE(rs1_data_ID_EXE), .rs2_data_ID_EXE(rs2_data_ID_EXE), .imm_ID_EXE(imm_ID_EXE),
        .rs1_ID_EXE(rs1_ID_EXE), .rs2_ID_EXE(rs2_ID_EXE), .rd_ID_EXE(rd_ID_EXE),
        .func_ID_EXE(func_ID_EXE), .mem_read_ID_EXE(mem_read_ID_EXE)
`ifdef ID_EXE_STATS_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [8:0]    ctrl;
        logic [DW-1:0] pc, rs1d, rs2d, imm;
        logic [AW-1:0] rs1, rs2, rd;
        logic [3:0]    func;
        int            bcnt, fcnt;
    } exp_t;

    exp_t model;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t zero_exp();
        exp_t z;
        z.valid = 1'b0; z.ctrl = 9'd0; z.pc = 32'd0; z.rs1d = 32'd0; z.rs2d = 32'd0; z.imm = 32'd0;
        z.rs1 = 5'd0; z.rs2 = 5'd0; z.rd = 5'd0; z.func = 4'd0; z.bcnt = 0; z.fcnt = 0;
        return z;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk("valid", 64'(valid_ID_EXE), 64'(e.valid));
        chk("ctrl", 64'(ctrl_ID_EXE), 64'(e.ctrl));
        chk("mem_read", 64'(mem_read_ID_EXE), 64'(e.ctrl[7]));
        chk("rd", 64'(rd_ID_EXE), 64'(e.rd));
        chk("rs1", 64'(rs1_ID_EXE), 64'(e.rs1));
        chk("rs2", 64'(rs2_ID_EXE), 64'(e.rs2));
        chk("pc", 64'(pc_ID_EXE), 64'(e.pc));
        chk("rs1_data", 64'(rs1_data_ID_EXE), 64'(e.rs1d));
        chk("rs2_data", 64'(rs2_data_ID_EXE), 64'(e.rs2d));
        chk("imm", 64'(imm_ID_EXE), 64'(e.imm));
        chk("func", 64'(func_ID_EXE), 64'(e.func));
`ifdef ID_EXE_STATS_EN
        chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bcnt));
        chk("flush_cnt", 64'(flush_cnt), 64'(e.fcnt));
`endif
    endtask

    // Apply one cycle of inputs and predict the slot contents after the next rising edge
    task automatic drive(input logic fl, input logic en, input logic st, input logic v,
                         input logic [8:0] c, input logic [DW-1:0] p,
                         input logic [AW-1:0] d, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        flush = fl; enable = en; stall_control = st; valid_IF_ID = v;
        ctrl_IF_ID = c; pc_IF_ID = p; rd_IF_ID = d; rs1_IF_ID = a1; rs2_IF_ID = a2;
        rs1_data_IF_ID = $urandom; rs2_data_IF_ID = $urandom; imm_IF_ID = $urandom;
        func_IF_ID = 4'($urandom);
        if (fl) begin
            if (model.valid) model.fcnt = sat_inc(model.fcnt);
            model.valid = 1'b0; model.ctrl = 9'd0; model.rd = 5'd0;
        end else if (!en) begin
            model.valid = model.valid;
        end else if (!st) begin
            model.bcnt = sat_inc(model.bcnt);
            model.valid = 1'b0; model.ctrl = 9'd0; model.rd = 5'd0; model.rs1 = 5'd0; model.rs2 = 5'd0;
        end else begin
            model.valid = v;
            model.ctrl  = v ? c : 9'd0;
            model.rd    = v ? d : 5'd0;
            model.pc = p; model.rs1d = rs1_data_IF_ID; model.rs2d = rs2_data_IF_ID;
            model.imm = imm_IF_ID; model.func = func_IF_ID; model.rs1 = a1; model.rs2 = a2;
        end
        sb_q.push_back(model);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next clock edge
    task automatic mid_reset();
        @(negedge clk);
        #1 arst_n = 1'b0;
        #1 model = zero_exp();
        compare_all(model);
        #1 arst_n = 1'b1;
        flush = 1'b0; enable = 1'b0;
        sb_q.push_back(model);
    endtask

    // Monitor: compare DUT slot contents against the scoreboard after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare_all(e);
            end
        end
    end

    initial begin
        model = zero_exp();
        repeat (2) @(negedge clk);
        compare_all(model);
        #1 arst_n = 1'b1;

        // Normal capture
        drive(1'b0, 1'b1, 1'b1, 1'b1, 9'h1C0, 32'h40, 5'd5, 5'd1, 5'd2);
        mid_reset();

        // Load-use: lw x5 enters EXE, add x6,x5,x7 bubbles once then captures
        drive(1'b0, 1'b1, 1'b1, 1'b1, 9'h1B0, 32'h44, 5'd5, 5'd3, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h102, 32'h48, 5'd6, 5'd5, 5'd7);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 9'h102, 32'h48, 5'd6, 5'd5, 5'd7);

        // Flush and stall on the same edge with a valid instruction in EXE
        drive(1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF, 32'h4C, 5'd9, 5'd9, 5'd9);

        // Invalid slot capture, then a valid one, then freeze and flush while frozen
        drive(1'b0, 1'b1, 1'b1, 1'b0, 9'h1FF, 32'h50, 5'd10, 5'd11, 5'd12);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 9'h0F3, 32'h54, 5'd13, 5'd14, 5'd15);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 1'($urandom), 1'b1, 9'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
        drive(1'b1, 1'b0, 1'b1, 1'b1, 9'h1FF, 32'h58, 5'd1, 5'd2, 5'd3);

        // Bubble counter saturation
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b1, 1'b0, 1'b1, 9'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0),
                  9'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
